// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair: default widths and the
// capture FSM state encoding.
package pwm_pkg;

  localparam int PWM_DATA_W      = 8;
  localparam int PWM_WINDOW_LOG2 = 8;

  typedef logic [0:0] pwm_state_t;
  localparam pwm_state_t PRIME = 1'b0;
  localparam pwm_state_t RUN   = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/pwm_sync_filter.sv
// Two-flop synchronizer for the asynchronous PWM line, optionally followed by a
// 3-sample majority filter when PWM_CAPTURE_FILTER_EN is defined.
module pwm_sync_filter
  import pwm_pkg::*;
(
  input  logic CLK_i,
  input  logic RST_i,
  input  logic PWM_i,
  output logic S_o
);

  logic [1:0] sync_q;

  always_ff @(posedge CLK_i) begin
    if (RST_i) sync_q <= '0;
    else       sync_q <= {sync_q[0], PWM_i};
  end

`ifdef PWM_CAPTURE_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;

  // Median of three consecutive synchronized samples drops single-cycle glitches.
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], sync_q[1]};
      filt_q <= maj3(sync_q[1], hist_q[0], hist_q[1]);
    end
  end

  assign S_o = filt_q;
`else
  assign S_o = sync_q[1];
`endif

endmodule

// File: rtl/pwm_capture.sv
// Duty-cycle decoder: counts high samples of the synchronized PWM line over a
// power-of-two window. Optional input glitch filter via PWM_CAPTURE_FILTER_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int DATA_W      = PWM_DATA_W,
  parameter int WINDOW_LOG2 = PWM_WINDOW_LOG2
) (
  input  logic              CLK_i,
  input  logic              RST_i,
  input  logic              EN_i,
  input  logic              PWM_i,
  output logic [DATA_W-1:0] DUTY_o,
  output logic              VALID_o,
  output logic              STATIC_o,
  output logic              LEVEL_o
);

  localparam logic [WINDOW_LOG2:0] DUTY_MAX = (WINDOW_LOG2+1)'((1 << DATA_W) - 1);

  logic s;

  pwm_sync_filter u_sync (
    .CLK_i (CLK_i),
    .RST_i (RST_i),
    .PWM_i (PWM_i),
    .S_o   (s)
  );

  pwm_state_t             state_q, state_d;
  logic [WINDOW_LOG2-1:0] win_cnt_q, win_cnt_d;
  logic [WINDOW_LOG2:0]   ones_q, ones_d;
  logic                   edge_q, edge_d;
  logic                   s_prev_q;
  logic [DATA_W-1:0]      duty_q, duty_d;
  logic                   valid_q, valid_d;
  logic                   static_q, static_d;
  logic                   level_q, level_d;

  logic                   win_end;
  logic [WINDOW_LOG2:0]   ones_total;
  logic [WINDOW_LOG2:0]   shifted;
  logic                   edge_total;

  // Totals include the current sample so the window-end cycle is counted too.
  assign win_end    = &win_cnt_q;
  assign ones_total = ones_q + (WINDOW_LOG2+1)'(s);
  assign edge_total = edge_q | (s ^ s_prev_q);
  assign shifted    = ones_total >> (WINDOW_LOG2 - DATA_W);

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    ones_d    = ones_q;
    edge_d    = edge_q;
    duty_d    = duty_q;
    valid_d   = 1'b0;
    static_d  = static_q;
    level_d   = level_q;
    if (!EN_i) begin
      state_d   = PRIME;
      win_cnt_d = '0;
      ones_d    = '0;
      edge_d    = 1'b0;
    end else begin
      win_cnt_d = win_cnt_q + WINDOW_LOG2'(1);
      if (win_end) begin
        ones_d = '0;
        edge_d = 1'b0;
        if (state_q == PRIME) begin
          state_d = RUN;
        end else begin
          duty_d   = (shifted > DUTY_MAX) ? DUTY_MAX[DATA_W-1:0] : shifted[DATA_W-1:0];
          static_d = ~edge_total;
          level_d  = s;
          valid_d  = 1'b1;
        end
      end else begin
        ones_d = ones_total;
        edge_d = edge_total;
      end
    end
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state_q   <= PRIME;
      win_cnt_q <= '0;
      ones_q    <= '0;
      edge_q    <= 1'b0;
      s_prev_q  <= 1'b0;
      duty_q    <= '0;
      valid_q   <= 1'b0;
      static_q  <= 1'b1;
      level_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      ones_q    <= ones_d;
      edge_q    <= edge_d;
      s_prev_q  <= s;
      duty_q    <= duty_d;
      valid_q   <= valid_d;
      static_q  <= static_d;
      level_q   <= level_d;
    end
  end

  assign DUTY_o   = duty_q;
  assign VALID_o  = valid_q;
  assign STATIC_o = static_q;
  assign LEVEL_o  = level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: drives a sigma-delta / constant / glitch
// source and predicts every output cycle from a sample-history reference model.
module tb_pwm_capture;

  localparam int WIN = 256;

`ifdef PWM_CAPTURE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic       CLK_i;
  logic       RST_i;
  logic       EN_i;
  logic       PWM_i;
  logic [7:0] DUTY_o;
  logic       VALID_o;
  logic       STATIC_o;
  logic       LEVEL_o;

  pwm_capture dut (
    .CLK_i    (CLK_i),
    .RST_i    (RST_i),
    .EN_i     (EN_i),
    .PWM_i    (PWM_i),
    .DUTY_o   (DUTY_o),
    .VALID_o  (VALID_o),
    .STATIC_o (STATIC_o),
    .LEVEL_o  (LEVEL_o)
  );

  initial CLK_i = 1'b0;
  always #5 CLK_i = ~CLK_i;

  bit         hist [0:16383];
  int         cyc;
  int         nextValid;
  int         stepValid;
  bit         prevRst;
  bit         rstDrive;
  bit         enDrive;
  int         mode;
  logic [7:0] sdD;
  logic [7:0] sdAcc;
  logic [7:0] expDuty;
  logic       expValid;
  logic       expStatic;
  logic       expLevel;
  int         passCount;
  int         checkCount;

  // Model of the line level seen by the window logic in cycle c.
  function automatic bit sAt(input int c);
    if (c < 5) return 1'b0;
    if (FILT)
      return (hist[c-3] & hist[c-4]) | (hist[c-3] & hist[c-5]) | (hist[c-4] & hist[c-5]);
    return hist[c-2];
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCount++;
    assert (obs === expv) passCount++;
    else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
  endtask

  task automatic checkOutput();
    int ones;
    bit edges;
    if (prevRst) begin
      expDuty   = 8'h00;
      expValid  = 1'b0;
      expStatic = 1'b1;
      expLevel  = 1'b0;
    end else if (cyc == nextValid) begin
      ones  = 0;
      edges = 1'b0;
      for (int k = cyc - WIN; k <= cyc - 1; k++) begin
        ones += int'(sAt(k));
        if (sAt(k) != sAt(k - 1)) edges = 1'b1;
      end
      expDuty   = (ones > 255) ? 8'hFF : 8'(ones);
      expStatic = ~edges;
      expLevel  = sAt(cyc - 1);
      expValid  = 1'b1;
      nextValid = nextValid + WIN;
    end else begin
      expValid = 1'b0;
    end
    checkVal("valid",  {31'd0, VALID_o},  {31'd0, expValid});
    checkVal("duty",   {24'd0, DUTY_o},   {24'd0, expDuty});
    checkVal("static", {31'd0, STATIC_o}, {31'd0, expStatic});
    checkVal("level",  {31'd0, LEVEL_o},  {31'd0, expLevel});
    if (cyc == stepValid)
      checkVal("stepMid", {31'd0, (DUTY_o > 8'h40) && (DUTY_o < 8'hC0)}, 32'd1);
  endtask

  task automatic applyStimulus();
    logic       p;
    logic [8:0] sum;
    case (mode)
      0: begin
        sum   = {1'b0, sdAcc} + {1'b0, sdD};
        sdAcc = sum[7:0];
        p     = sum[8];
      end
      1:       p = 1'b1;
      3:       p = (cyc % 16 == 0);
      default: p = 1'b0;
    endcase
    RST_i     = rstDrive;
    EN_i      = enDrive;
    PWM_i     = p;
    hist[cyc] = p;
    if (rstDrive || !enDrive) nextValid = cyc + 1 + 2 * WIN;
    prevRst = rstDrive;
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      checkOutput();
      applyStimulus();
      @(posedge CLK_i);
      #1;
      cyc++;
    end
  endtask

  function automatic int cyclesUntil(input int target);
    int n;
    n = target - cyc;
    while (n < 1) n += WIN;
    return n;
  endfunction

  initial begin
    logic [7:0] sweep [3];
    passCount  = 0;
    checkCount = 0;
    stepValid  = -1;
    nextValid  = -1;
    mode       = 2;
    sdD        = 8'h00;
    sdAcc      = 8'h00;
    rstDrive   = 1'b1;
    enDrive    = 1'b1;
    RST_i      = 1'b1;
    EN_i       = 1'b1;
    PWM_i      = 1'b0;
    cyc        = 0;
    hist[0]    = 1'b0;
    @(posedge CLK_i);
    #1;
    cyc     = 1;
    prevRst = 1'b1;

    $display("[TB] reset and D=0x80 sigma-delta");
    runCycles(1);
    rstDrive = 1'b0;
    mode     = 0;
    sdD      = 8'h80;
    sdAcc    = 8'h00;
    runCycles(2 * WIN + 3 * WIN);

    $display("[TB] line held high, then held low");
    mode = 1;
    runCycles(3 * WIN);
    mode = 2;
    runCycles(3 * WIN);

    $display("[TB] duty sweep with random phase");
    sweep[0] = 8'h01;
    sweep[1] = 8'h40;
    sweep[2] = 8'hFE;
    mode = 0;
    for (int i = 0; i < 3; i++) begin
      sdD   = sweep[i];
      sdAcc = 8'($urandom);
      runCycles(3 * WIN);
    end

    $display("[TB] duty step 0x40 to 0xC0 mid-window");
    sdD = 8'h40;
    runCycles(2 * WIN);
    runCycles(cyclesUntil(nextValid - 128));
    stepValid = nextValid;
    sdD       = 8'hC0;
    runCycles(3 * WIN);

    $display("[TB] reset at win_cnt=100 in RUN");
    runCycles(cyclesUntil(nextValid - 156));
    rstDrive = 1'b1;
    runCycles(1);
    rstDrive = 1'b0;
    sdAcc    = 8'($urandom);
    runCycles(3 * WIN);

    $display("[TB] enable dropped for 10 cycles");
    enDrive = 1'b0;
    runCycles(10);
    enDrive = 1'b1;
    runCycles(3 * WIN);

    $display("[TB] enable dropped on a window-end cycle");
    runCycles(cyclesUntil(nextValid - 1));
    enDrive = 1'b0;
    runCycles(1);
    enDrive = 1'b1;
    runCycles(3 * WIN);

    $display("[TB] low line with single-cycle glitches");
    mode = 3;
    runCycles(4 * WIN);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
